// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble).
// Latency: WIDTH cycles from accepted start to done; bcd/blank update with done.
// Backpressure: none; start is only sampled in IDLE, ignored while busy, never queued.
// Optional feature: define BIN2BCD_BLANK_EN to register per-digit leading-zero blank flags.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                    state;
  logic [WIDTH-1:0]          shreg;
  logic [4*DIGITS-1:0]       scratch;
  logic [CW-1:0]             cnt;

  logic [4*DIGITS-1:0]       adj;
  logic [4*DIGITS+WIDTH-1:0] shifted;
  logic [4*DIGITS-1:0]       nxt_scratch;
  logic [WIDTH-1:0]          nxt_shreg;
  logic                      last_shift;

  // Pre-shift correction: any digit >= 5 would exceed 9 after doubling, so bias it by 3.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // The binary MSB walks into the BCD units digit as the pair shifts left.
  assign shifted     = {adj, shreg} << 1;
  assign nxt_scratch = shifted[4*DIGITS+WIDTH-1:WIDTH];
  assign nxt_shreg   = shifted[WIDTH-1:0];
  assign last_shift  = (state == SHIFT) && (cnt == CW'(1));

  // Conversion FSM: capture in IDLE, WIDTH shift cycles, publish result on the final one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= nxt_scratch;
          shreg   <= nxt_shreg;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd   <= nxt_scratch;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] nxt_blank;
  logic [DIGITS-1:0] blank_q;
  logic              allz;

  // A digit blanks only if it and every digit above it are zero; units never blanks.
  always_comb begin
    nxt_blank = '0;
    allz      = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      allz         = allz & (nxt_scratch[4*i +: 4] == 4'd0);
      nxt_blank[i] = allz;
    end
  end

  // Blank flags update in the same edge as bcd so the display never sees a mixed state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blank_q <= '0;
    end else if (last_shift) begin
      blank_q <= nxt_blank;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, scoreboard of expected results,
// plus hand sequences for ignored start, back-to-back start and mid-conversion reset.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  blank;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] bcd;
    logic [4:0]  blank;
  } exp_t;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [4:0]  blank_m;
  } vec_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  logic [19:0] prev_bcd = '0;
  logic [4:0]  prev_blank = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] eff_blank(input logic [4:0] m);
`ifdef BIN2BCD_BLANK_EN
    return m;
`else
    return 5'b00000 & m;
`endif
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      exp_t e;
      logic ok;
      done_cnt++;
      check("sb_nonempty_at_done", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("bcd", bcd, e.bcd);
        check("blank", blank, e.blank);
      end
      ok = 1'b1;
      for (int i = 0; i < 5; i++) if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
      check("nibble_range", ok, 1);
    end
  end

  // Drive one conversion request in the current slot and follow it to done.
  task automatic convert(input logic [15:0] v, input logic [19:0] eb, input logic [4:0] ebl,
                         input int inject, output int dcyc);
    int   lat;
    logic seen;
    exp_t e;
    bin   = v;
    start = 1'b1;
    e.bcd   = eb;
    e.blank = eff_blank(ebl);
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_low_after_start", done, 0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done === 1'b1) begin
        seen = 1'b1;
        check("busy_low_in_done_cycle", busy, 0);
      end else begin
        check("busy_held", busy, 1);
        check("bcd_held", bcd, prev_bcd);
        check("blank_held", blank, prev_blank);
      end
      if (inject > 0 && lat == inject) begin
        bin   = 16'd9;
        start = 1'b1;
      end else if (inject > 0 && lat == inject + 1) begin
        start = 1'b0;
      end
    end
    check("latency", lat, 16);
    prev_bcd   = eb;
    prev_blank = eff_blank(ebl);
    dcyc       = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[13];
    int   d1, d2, dc0;

    vecs[0]  = '{16'd0,     20'h00000, 5'b11110};
    vecs[1]  = '{16'd65535, 20'h65535, 5'b00000};
    vecs[2]  = '{16'd1234,  20'h01234, 5'b10000};
    vecs[3]  = '{16'd9,     20'h00009, 5'b11110};
    vecs[4]  = '{16'd4321,  20'h04321, 5'b10000};
    vecs[5]  = '{16'd999,   20'h00999, 5'b11000};
    vecs[6]  = '{16'd10,    20'h00010, 5'b11100};
    vecs[7]  = '{16'd100,   20'h00100, 5'b11000};
    vecs[8]  = '{16'd59999, 20'h59999, 5'b00000};
    vecs[9]  = '{16'd40000, 20'h40000, 5'b00000};
    vecs[10] = '{16'd1,     20'h00001, 5'b11110};
    vecs[11] = '{16'd10000, 20'h10000, 5'b00000};
    vecs[12] = '{16'd7,     20'h00007, 5'b11110};

    rst   = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_bcd", bcd, 0);
    check("reset_blank", blank, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table sweep, idle cycle between conversions.
    for (int i = 0; i < 13; i++) begin
      convert(vecs[i].bin, vecs[i].bcd, vecs[i].blank_m, 0, d1);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
    end

    // start while busy (with bin changed) must be ignored.
    dc0 = done_cnt;
    convert(16'd1234, 20'h01234, 5'b10000, 5, d1);
    @(posedge clk); #1;
    check("ignored_start_done_count", done_cnt - dc0, 1);
    check("ignored_start_idle", busy, 0);

    // start in the done cycle is accepted: results 17 cycles apart.
    convert(16'd4321, 20'h04321, 5'b10000, 0, d1);
    convert(16'd9,    20'h00009, 5'b11110, 0, d2);
    check("b2b_spacing", d2 - d1, 17);
    @(posedge clk); #1;
    check("b2b_done_one_cycle", done, 0);

    // Reset in the 8th busy cycle aborts with no done.
    begin
      exp_t e;
      dc0     = done_cnt;
      bin     = 16'd999;
      start   = 1'b1;
      e.bcd   = 20'h00999;
      e.blank = eff_blank(5'b11000);
      exp_q.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      check("abort_busy_before_reset", busy, 1);
      rst = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_bcd", bcd, 0);
      check("abort_done", done, 0);
      check("abort_blank", blank, 0);
      void'(exp_q.pop_back());
      prev_bcd   = '0;
      prev_blank = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - dc0, 0);
      check("abort_idle", busy, 0);
      convert(16'd999, 20'h00999, 5'b11000, 0, d1);
      @(posedge clk); #1;
    end

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16: binary input width.
REQ-002 SHALL have parameter DIGITS, default 5: BCD output digits; DIGITS*4 SHALL be at least enough to hold 2^WIDTH-1.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to convert bin; sampled only in IDLE.
REQ-006 SHALL have port bin, input, WIDTH: unsigned binary value.
REQ-007 SHALL have port busy, output, 1: high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1: one-cycle pulse marking a new result on bcd.
REQ-009 SHALL have port bcd, output, 4*DIGITS: packed digits, digit 0 (units) in bits [3:0]; each nibble feeds one 7-segment decoder.
REQ-010 SHALL have port blank, output, DIGITS: per-digit leading-zero blank flag (see Configuration).

Function
REQ-011 SHALL implement a two-state FSM, IDLE and SHIFT, using iterative shift-add-3 (double dabble).
REQ-012 In IDLE with start=1 at edge T: SHALL capture bin into a shift register, clear the BCD scratch, load the bit counter with WIDTH, and enter SHIFT.
REQ-013 Each SHIFT cycle: SHALL first add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one bit.
REQ-014 After exactly WIDTH SHIFT cycles: SHALL copy scratch to bcd, pulse done for one cycle, and return to IDLE.
REQ-015 Latency: busy SHALL be 1 from edge T+1 through edge T+WIDTH; bcd update and done=1 SHALL both occur at edge T+WIDTH (visible in cycle T+WIDTH..T+WIDTH+1).
REQ-016 busy SHALL be 0 whenever the FSM is in IDLE, including the cycle in which done=1.
REQ-017 start while busy=1 SHALL be ignored, with no queuing and no effect on the running conversion.
REQ-018 start asserted in the cycle where done=1 SHALL be accepted, giving a back-to-back conversion of WIDTH+1 cycles per result.
REQ-019 bcd and blank SHALL hold the previous result for the entire conversion; changes to bin after capture SHALL have no effect.
REQ-020 Every bcd nibble SHALL be in the range 0-9 for every output value.

Reset
REQ-021 rst=0 SHALL immediately force: FSM=IDLE, busy=0, done=0, bcd=0, blank=0, counter=0, scratch=0, regardless of clk.
REQ-022 Reset asserted mid-conversion SHALL abort it; no done pulse SHALL follow.
REQ-023 After rst deasserts, the first start SHALL behave as in REQ-012.

Configuration
REQ-024 Macro BIN2BCD_BLANK_EN, when defined: blank[i] SHALL be registered with bcd at the done edge; blank[i]=1 iff digit i and all higher digits are 0, for i>=1. blank[0] SHALL always be 0.
REQ-025 Without BIN2BCD_BLANK_EN: blank SHALL be constant 0; no blank logic is synthesized; all other behaviour SHALL be unchanged.

Verification
REQ-026 Reset, then bin=0 and start pulse -> done exactly 16 cycles later, bcd=0x00000, with macro blank=5'b11110.
REQ-027 bin=65535 and start -> bcd=0x65535, blank=5'b00000, busy high for 16 cycles.
REQ-028 bin=1234 and start; during busy, change bin to 9 and pulse start -> bcd=0x01234 only, with macro blank=5'b10000, exactly one done pulse.
REQ-029 Conversion of 4321 completes; start is re-pulsed in the done cycle with bin=9 -> second done 17 cycles after the first, bcd=0x00009, with macro blank=5'b11110.
REQ-030 Start bin=999 and assert rst at the 8th busy cycle -> busy=0, bcd=0 immediately, no done; a restart then yields 0x00999.
